// File: rtl/wb_sched.sv
// -----------------------------------------------------------------------------
// wb_sched -- write-back scheduler for a single register-file write port.
//
// The pipeline WB slot and a long-latency unit (MUL/DIV) share one RF write
// port. Long-latency results wait in a 2-entry FIFO. The pipeline normally has
// priority. When the FIFO head has waited STARVE_LIMIT cycles while the
// pipeline keeps writing, the scheduler enters a one-cycle FORCE state. In
// that cycle it stalls the pipeline and drains the FIFO head.
//
// Optional feature: define WB_SCHED_BYPASS_EN to let a long-latency result
// write the RF directly (no FIFO trip) when the FIFO is empty, the pipeline is
// idle and the scheduler is not in FORCE.
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   pipe_valid     pipeline WB slot holds a write
//   pipe_rd        pipeline destination register
//   pipe_is_load   1: write pipe_mem_data, 0: write pipe_result
//   pipe_result    ALU result
//   pipe_mem_data  load data
//   pipe_stall     pipeline must hold its WB slot this cycle
//   lu_valid       long-latency unit offers a result
//   lu_rd          long-latency destination register
//   lu_data        long-latency result
//   lu_ready       scheduler accepts the lu result this cycle
//   rf_we          RF write enable (registered)
//   rf_waddr       RF write address (registered)
//   rf_wdata       RF write data (registered)
// -----------------------------------------------------------------------------
module wb_sched #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic        pipe_is_load,
    input  logic [63:0] pipe_result,
    input  logic [63:0] pipe_mem_data,
    output logic        pipe_stall,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [63:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    localparam logic [2:0] STARVE_LIM_C = 3'(STARVE_LIMIT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [4:0]  fifo_rd_r   [0:1];
    logic [63:0] fifo_data_r [0:1];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  count_r;
    logic [2:0]  age_r;

    logic        fifo_empty_s;
    logic [4:0]  head_rd_s;
    logic [63:0] head_data_s;
    logic        push_s;
    logic        pop_s;
    logic        bypass_s;
    logic        sel_valid_s;
    logic [4:0]  sel_addr_s;
    logic [63:0] sel_data_s;
    logic        sel_we_s;

    assign fifo_empty_s = (count_r == 2'd0);
    assign head_rd_s    = fifo_rd_r[rd_ptr_r];
    assign head_data_s  = fifo_data_r[rd_ptr_r];
    // Ready depends only on the registered count, never on a same-cycle pop.
    assign lu_ready     = (count_r < 2'd2);
    assign push_s       = lu_valid && lu_ready && !bypass_s;
    assign pipe_stall   = (state_r == ST_FORCE);
    // A destination of x0 is never written, but the source is still consumed.
    assign sel_we_s     = sel_valid_s && (sel_addr_s != 5'd0);

    // Write-source selection and next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        sel_valid_s = 1'b0;
        sel_addr_s  = 5'd0;
        sel_data_s  = 64'd0;
        pop_s       = 1'b0;
        bypass_s    = 1'b0;
        case (state_r)
            ST_FORCE: begin
                // Entered only with a non-empty FIFO; the empty test is a guard.
                if (!fifo_empty_s) begin
                    sel_valid_s = 1'b1;
                    sel_addr_s  = head_rd_s;
                    sel_data_s  = head_data_s;
                    pop_s       = 1'b1;
                end else begin
                    sel_valid_s = 1'b0;
                end
                state_nxt_s = ST_NORMAL;
            end
            ST_NORMAL: begin
                if (pipe_valid) begin
                    sel_valid_s = 1'b1;
                    sel_addr_s  = pipe_rd;
                    sel_data_s  = pipe_is_load ? pipe_mem_data : pipe_result;
                    if (!fifo_empty_s && (age_r >= STARVE_LIM_C)) begin
                        state_nxt_s = ST_FORCE;
                    end else begin
                        state_nxt_s = ST_NORMAL;
                    end
                end else if (!fifo_empty_s) begin
                    sel_valid_s = 1'b1;
                    sel_addr_s  = head_rd_s;
                    sel_data_s  = head_data_s;
                    pop_s       = 1'b1;
                end else begin
`ifdef WB_SCHED_BYPASS_EN
                    if (lu_valid) begin
                        sel_valid_s = 1'b1;
                        sel_addr_s  = lu_rd;
                        sel_data_s  = lu_data;
                        bypass_s    = 1'b1;
                    end else begin
                        bypass_s    = 1'b0;
                    end
`else
                    sel_valid_s = 1'b0;
`endif
                end
            end
            default: begin
                state_nxt_s = ST_NORMAL;
            end
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_NORMAL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO storage, pointers and occupancy; a simultaneous push and pop keeps
    // the count and queues the new entry behind the surviving head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_rd_r[i]   <= 5'd0;
                fifo_data_r[i] <= 64'd0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_rd_r[wr_ptr_r]   <= lu_rd;
                fifo_data_r[wr_ptr_r] <= lu_data;
                wr_ptr_r              <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head age: counts cycles the head waits unserved, saturating at 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_r <= 3'd0;
        end else if (pop_s || fifo_empty_s) begin
            age_r <= 3'd0;
        end else if (age_r != 3'd7) begin
            age_r <= age_r + 3'd1;
        end else begin
            age_r <= age_r;
        end
    end

    // Registered RF write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 64'd0;
        end else begin
            rf_we    <= sel_we_s;
            rf_waddr <= sel_addr_s;
            rf_wdata <= sel_data_s;
        end
    end

endmodule
